regfile_debug_dumper: RTL and testbench

//  Debug sequencer for the decode-stage register file.
//  - On request: freezes the pipeline, walks the register-file debug read port

---
 rtl/regfile_debug_dumper.sv | 218 +++++++++++++++++++++
 tb/tb_regfile_debug_dumper.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_dumper.sv
// regfile_debug_dumper
// Dumps the register file to the debug byte stream when the debug unit asks.
// The pipeline is frozen for the whole dump. Registers 0..NUM_REGS-1 are read
// through the debug read port, and each 32-bit value is sent MSB-first over a
// valid/ready byte channel. An optional XOR checksum byte follows the last
// register.
//
// Ports
//   i_clk           clock, all state changes on posedge
//   i_rst           asynchronous active-high reset
//   i_dump_req      start request, only looked at in IDLE
//   i_dump_abort    stop the dump; takes effect once the current word is done
//   o_busy          high whenever not IDLE
//   o_dump_done     one-cycle pulse when a dump completes (never on abort)
//   o_dbg_on        register-file debug mode (blocks writeback writes)
//   o_dbg_stop      pipeline stall to decode/fetch
//   o_dbg_read_reg  debug read address
//   i_dbg_reg_data  debug read data, valid READ_LAT cycles after the address
//   o_tx_valid      byte available on o_tx_data
//   o_tx_data       byte to transmit
//   i_tx_ready      sink accepts the byte this cycle
//
// state  | meaning
// IDLE   | waiting for i_dump_req, debug mode off
// FREEZE | pipeline stalled and debug mode on, one settling cycle
// READ   | address driven, waiting READ_LAT cycles for read data
// SEND   | streaming the four bytes of the current register
// CSUM   | streaming the checksum byte
// DONE   | completion pulse, then back to IDLE
module regfile_debug_dumper #(
  parameter int NUM_REGS      = 32,
  parameter int READ_LAT      = 1,
  parameter bit SEND_CHECKSUM = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dump_req,
  input  logic        i_dump_abort,
  output logic        o_busy,
  output logic        o_dump_done,
  output logic        o_dbg_on,
  output logic        o_dbg_stop,
  output logic [4:0]  o_dbg_read_reg,
  input  logic [31:0] i_dbg_reg_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_READ, S_SEND, S_CSUM, S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_dbg;
  logic [4:0]  r_rd_reg;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic [4:0]  r_idx;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_csum;
  logic [23:0] r_shift;      // bytes of the current word still to be sent
  logic [1:0]  r_lat_cnt;
  logic        r_abort_pend; // abort seen earlier in this word, not yet acted on

  logic       w_xfer;
  logic       w_abort;
  logic       w_last;
  logic [7:0] w_csum_next;

  assign w_xfer      = r_tx_valid & i_tx_ready;
  assign w_abort     = i_dump_abort | r_abort_pend;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_csum_next = r_csum ^ r_tx_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dbg        <= 1'b0;
      r_rd_reg     <= 5'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'd0;
      r_idx        <= 5'd0;
      r_byte_cnt   <= 2'd0;
      r_csum       <= 8'd0;
      r_shift      <= 24'd0;
      r_lat_cnt    <= 2'd0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A short abort pulse must survive until the word boundary.
      if (r_state != S_IDLE && i_dump_abort)
        r_abort_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_abort_pend <= 1'b0;
          // abort wins over a simultaneous request
          if (i_dump_req && !i_dump_abort) begin
            r_state    <= S_FREEZE;
            r_busy     <= 1'b1;
            r_dbg      <= 1'b1;
            r_idx      <= 5'd0;
            r_csum     <= 8'd0;
            r_byte_cnt <= 2'd0;
          end
        end

        S_FREEZE: begin
          if (w_abort) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_dbg        <= 1'b0;
            r_abort_pend <= 1'b0;
          end else begin
            r_state   <= S_READ;
            r_rd_reg  <= r_idx;
            r_lat_cnt <= LAT_INIT;
          end
        end

        S_READ: begin
          if (w_abort) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_dbg        <= 1'b0;
            r_abort_pend <= 1'b0;
          end else if (r_lat_cnt == 2'd0) begin
            r_state    <= S_SEND;
            r_tx_valid <= 1'b1;
            r_tx_data  <= i_dbg_reg_data[31:24];
            r_shift    <= i_dbg_reg_data[23:0];
            r_byte_cnt <= 2'd0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end

        S_SEND: begin
          if (w_xfer) begin
            r_csum     <= w_csum_next;
            r_tx_data  <= r_shift[23:16];
            r_shift    <= {r_shift[15:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_tx_valid <= 1'b0;
              if (w_abort) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_dbg        <= 1'b0;
                r_abort_pend <= 1'b0;
              end else if (w_last) begin
                if (SEND_CHECKSUM) begin
                  r_state    <= S_CSUM;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_csum_next;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_state   <= S_READ;
                r_idx     <= r_idx + 5'd1;
                r_rd_reg  <= r_idx + 5'd1;
                r_lat_cnt <= LAT_INIT;
              end
            end
          end
        end

        S_CSUM: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            if (w_abort) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_dbg        <= 1'b0;
              r_abort_pend <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_dbg        <= 1'b0;
          r_abort_pend <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_dbg      <= 1'b0;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_dump_done    = r_done;
  assign o_dbg_on       = r_dbg;
  assign o_dbg_stop     = r_dbg;
  assign o_dbg_read_reg = r_rd_reg;
  assign o_tx_valid     = r_tx_valid;
  assign o_tx_data      = r_tx_data;

endmodule

// File: tb/tb_regfile_debug_dumper.sv
module tb_regfile_debug_dumper;

  logic clk = 1'b0;
  logic rst;
  logic tx_ready;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        req_a, abort_a, busy_a, done_a, on_a, stop_a, valid_a;
  logic [4:0]  rd_a;
  logic [31:0] data_a;
  logic [7:0]  txd_a;
  // DUT B: 8 registers, 3-cycle read latency, no checksum
  logic        req_b, abort_b, busy_b, done_b, on_b, stop_b, valid_b;
  logic [4:0]  rd_b;
  logic [31:0] data_b;
  logic [7:0]  txd_b;

  regfile_debug_dumper u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_dump_req(req_a), .i_dump_abort(abort_a),
    .o_busy(busy_a), .o_dump_done(done_a), .o_dbg_on(on_a), .o_dbg_stop(stop_a),
    .o_dbg_read_reg(rd_a), .i_dbg_reg_data(data_a),
    .o_tx_valid(valid_a), .o_tx_data(txd_a), .i_tx_ready(tx_ready));

  regfile_debug_dumper #(.NUM_REGS(8), .READ_LAT(3), .SEND_CHECKSUM(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_dump_req(req_b), .i_dump_abort(abort_b),
    .o_busy(busy_b), .o_dump_done(done_b), .o_dbg_on(on_b), .o_dbg_stop(stop_b),
    .o_dbg_read_reg(rd_b), .i_dbg_reg_data(data_b),
    .o_tx_valid(valid_b), .o_tx_data(txd_b), .i_tx_ready(tx_ready));

  // Register file models: A answers within the cycle, B three cycles after
  // the address changes.
  logic [31:0] regs_a [32];
  logic [31:0] regs_b [8];
  logic [4:0]  rd_b_d1, rd_b_d2;
  assign data_a = regs_a[rd_a];
  always @(posedge clk) begin
    rd_b_d1 <= rd_b;
    rd_b_d2 <= rd_b_d1;
  end
  assign data_b = regs_b[rd_b_d2[2:0]];

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] exp_q[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Byte collector plus handshake stability checks, sampled mid-cycle.
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] held_a, held_b;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_a = 1'b0;
        stall_b = 1'b0;
      end else begin
        if (stall_a) begin
          n_vec++;
          if (!valid_a || txd_a !== held_a) begin
            n_err++;
            $display("FAIL stall_hold_a: valid=%0b data=%h, required valid=1 data=%h", valid_a, txd_a, held_a);
          end
        end
        if (stall_b) begin
          n_vec++;
          if (!valid_b || txd_b !== held_b) begin
            n_err++;
            $display("FAIL stall_hold_b: valid=%0b data=%h, required valid=1 data=%h", valid_b, txd_b, held_b);
          end
        end
        if (valid_a && tx_ready) got_a.push_back(txd_a);
        if (valid_b && tx_ready) got_b.push_back(txd_b);
        stall_a = valid_a && !tx_ready;
        stall_b = valid_b && !tx_ready;
        held_a  = txd_a;
        held_b  = txd_b;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference stream: registers 0..last, MSB first, optional XOR byte.
  task automatic build_exp(input bit sel_b, input int last, input bit with_csum);
    logic [7:0]  c;
    logic [31:0] w;
    exp_q.delete();
    c = 8'h00;
    for (int i = 0; i <= last; i++) begin
      w = sel_b ? regs_b[i[2:0]] : regs_a[i[4:0]];
      for (int k = 3; k >= 0; k--) begin
        exp_q.push_back(w[k*8 +: 8]);
        c = c ^ w[k*8 +: 8];
      end
    end
    if (with_csum) exp_q.push_back(c);
  endtask

  function automatic logic [7:0] qget(input bit sel_b, input bit from_exp, input int i);
    if (from_exp) return (i < exp_q.size()) ? exp_q[i] : 8'hxx;
    if (sel_b)    return (i < got_b.size()) ? got_b[i] : 8'hxx;
    return (i < got_a.size()) ? got_a[i] : 8'hxx;
  endfunction

  function automatic int first_diff(input bit sel_b);
    int n, m, lim;
    n = sel_b ? got_b.size() : got_a.size();
    m = exp_q.size();
    lim = (n < m) ? n : m;
    for (int i = 0; i < lim; i++)
      if (qget(sel_b, 1'b0, i) !== exp_q[i]) return i;
    if (n != m) return lim;
    return -1;
  endfunction

  task automatic pulse_req(input bit sel_b);
    @(posedge clk); #1;
    if (sel_b) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    if (sel_b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  task automatic wait_idle(input bit sel_b, input string name, input int budget);
    int c = 0;
    while ((sel_b ? busy_b : busy_a) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (sel_b ? busy_b : busy_a) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_a = 0; abort_a = 0; req_b = 0; abort_b = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy_a, done_a, on_a, stop_a, valid_a, rd_a, txd_a} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_a: busy=%0b done=%0b on=%0b stop=%0b valid=%0b rd=%0d data=%h, required all 0",
               busy_a, done_a, on_a, stop_a, valid_a, rd_a, txd_a);
    end
    n_vec++;
    if ({busy_b, done_b, on_b, stop_b, valid_b, rd_b, txd_b} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_b: busy=%0b done=%0b on=%0b stop=%0b valid=%0b rd=%0d data=%h, required all 0",
               busy_b, done_b, on_b, stop_b, valid_b, rd_b, txd_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_dump;
    int cyc, d;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'h01010101 * 32'(i);
    rdy_mode = 0;
    got_a.delete(); done_cnt_a = 0;
    pulse_req(1'b0);   // now just after the edge that sampled the request
    n_vec++;
    if ({busy_a, on_a, stop_a, valid_a} !== 4'b1110) begin
      n_err++;
      $display("FAIL freeze_outputs: busy/on/stop/valid=%b, required 1110", {busy_a, on_a, stop_a, valid_a});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({valid_a, rd_a} !== 6'd0) begin
      n_err++;
      $display("FAIL read_r0: valid=%0b rd=%0d, required valid=0 rd=0", valid_a, rd_a);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({valid_a, txd_a} !== 9'h100) begin
      n_err++;
      $display("FAIL first_byte: valid=%0b data=%h, required valid=1 data=00", valid_a, txd_a);
    end
    cyc = 2;
    while (!done_a && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    // FREEZE, then 32 registers of (1 read + 4 bytes), then the checksum byte
    n_vec++;
    if (cyc !== 1 + 32 * 5 + 1) begin
      n_err++;
      $display("FAIL dump_latency: done after %0d edges, required %0d", cyc, 1 + 32 * 5 + 1);
    end
    wait_idle(1'b0, "full_dump", 50);
    build_exp(1'b0, 31, 1'b1);
    d = first_diff(1'b0);
    n_vec++;
    if (d !== -1) begin
      n_err++;
      $display("FAIL full_stream: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qget(1'b0, 1'b0, d), got_a.size(), qget(1'b0, 1'b1, d), exp_q.size());
    end
    n_vec++;
    if (done_cnt_a !== 1) begin
      n_err++;
      $display("FAIL full_done: %0d pulses, required 1", done_cnt_a);
    end
  endtask

  task automatic test_backpressure;
    int d;
    rdy_mode = 1;
    got_a.delete(); done_cnt_a = 0;
    pulse_req(1'b0);
    wait_idle(1'b0, "backpressure", 1000);
    build_exp(1'b0, 31, 1'b1);
    d = first_diff(1'b0);
    n_vec++;
    if (d !== -1) begin
      n_err++;
      $display("FAIL toggle_stream: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qget(1'b0, 1'b0, d), got_a.size(), qget(1'b0, 1'b1, d), exp_q.size());
    end
    n_vec++;
    if (done_cnt_a !== 1) begin
      n_err++;
      $display("FAIL toggle_done: %0d pulses, required 1", done_cnt_a);
    end
    rdy_mode = 0;
  endtask

  task automatic test_abort;
    int c, d;
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    rdy_mode = 2;
    got_a.delete(); done_cnt_a = 0;
    pulse_req(1'b0);
    c = 0;
    while (got_a.size() < 21 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    // first byte of r5 has just transferred; the second is on the bus
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    wait_idle(1'b0, "abort", 200);
    build_exp(1'b0, 5, 1'b0);
    d = first_diff(1'b0);
    n_vec++;
    if (d !== -1) begin
      n_err++;
      $display("FAIL abort_stream: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qget(1'b0, 1'b0, d), got_a.size(), qget(1'b0, 1'b1, d), exp_q.size());
    end
    n_vec++;
    if ({busy_a, on_a, stop_a, valid_a} !== 4'b0000 || done_cnt_a !== 0) begin
      n_err++;
      $display("FAIL abort_state: busy/on/stop/valid=%b done_pulses=%0d, required 0000 and 0",
               {busy_a, on_a, stop_a, valid_a}, done_cnt_a);
    end
    rdy_mode = 0;
  endtask

  task automatic test_early_abort;
    @(posedge clk); #1;
    req_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; abort_a = 1'b0;
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL req_abort_idle: busy=%0b, required 0", busy_a);
    end
    got_a.delete(); done_cnt_a = 0;
    pulse_req(1'b0);   // in FREEZE now
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    n_vec++;
    if ({busy_a, on_a, stop_a, valid_a} !== 4'b0000) begin
      n_err++;
      $display("FAIL freeze_abort: busy/on/stop/valid=%b, required 0000", {busy_a, on_a, stop_a, valid_a});
    end
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (got_a.size() !== 0 || done_cnt_a !== 0) begin
      n_err++;
      $display("FAIL freeze_abort_quiet: %0d bytes %0d done pulses, required 0 and 0", got_a.size(), done_cnt_a);
    end
  endtask

  task automatic test_reset_mid_dump;
    int c, d;
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    rdy_mode = 2;
    pulse_req(1'b0);
    c = 0;
    while (!(rd_a == 5'd10 && valid_a) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({valid_a, stop_a, busy_a, on_a, done_a, rd_a, txd_a} !== 18'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%0b stop=%0b busy=%0b on=%0b rd=%0d data=%h, required all 0",
               valid_a, stop_a, busy_a, on_a, rd_a, txd_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    got_a.delete(); done_cnt_a = 0;
    pulse_req(1'b0);
    wait_idle(1'b0, "restart", 1500);
    build_exp(1'b0, 31, 1'b1);
    d = first_diff(1'b0);
    n_vec++;
    if (d !== -1) begin
      n_err++;
      $display("FAIL restart_stream: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qget(1'b0, 1'b0, d), got_a.size(), qget(1'b0, 1'b1, d), exp_q.size());
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back;
    int d;
    got_a.delete(); done_cnt_a = 0;
    @(posedge clk); #1;
    req_a = 1'b1;
    @(posedge clk); #1;
    wait_idle(1'b0, "held_req", 400);
    build_exp(1'b0, 31, 1'b1);
    d = first_diff(1'b0);
    n_vec++;
    if (d !== -1 || done_cnt_a !== 1) begin
      n_err++;
      $display("FAIL held_req_first: diff at %0d done_pulses=%0d, required none and 1", d, done_cnt_a);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL held_req_restart: busy=%0b after one idle cycle, required 1", busy_a);
    end
    req_a = 1'b0;
    got_a.delete(); done_cnt_a = 0;
    repeat (10) @(posedge clk);
    #1;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    wait_idle(1'b0, "busy_req", 400);
    d = first_diff(1'b0);
    n_vec++;
    if (d !== -1 || done_cnt_a !== 1) begin
      n_err++;
      $display("FAIL held_req_second: diff at %0d done_pulses=%0d, required none and 1", d, done_cnt_a);
    end
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL busy_req_queued: busy=%0b, required 0", busy_a);
    end
  endtask

  task automatic test_read_latency;
    int c, d, rd7;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) regs_b[i] = $urandom;
    regs_b[7] = 32'hDEADBEEF;
    rdy_mode = 0;
    got_b.delete(); done_cnt_b = 0;
    pulse_req(1'b1);
    c = 0; rd7 = 0;
    while (busy_b && c < 500) begin
      if (rd_b == 5'd7 && !valid_b && !done_b) rd7++;
      @(posedge clk); #1;
      c++;
    end
    n_vec++;
    if (rd7 !== 3) begin
      n_err++;
      $display("FAIL read_lat_hold: r7 address held %0d cycles before sending, required 3", rd7);
    end
    build_exp(1'b1, 7, 1'b0);
    d = first_diff(1'b1);
    n_vec++;
    if (d !== -1) begin
      n_err++;
      $display("FAIL lat3_stream: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qget(1'b1, 1'b0, d), got_b.size(), qget(1'b1, 1'b1, d), exp_q.size());
    end
    w = {qget(1'b1, 1'b0, 28), qget(1'b1, 1'b0, 29), qget(1'b1, 1'b0, 30), qget(1'b1, 1'b0, 31)};
    n_vec++;
    if (w !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL r7_bytes: got %h, required deadbeef", w);
    end
    n_vec++;
    if (done_cnt_b !== 1) begin
      n_err++;
      $display("FAIL lat3_done: %0d pulses, required 1", done_cnt_b);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_early_abort();
    test_reset_mid_dump();
    test_back_to_back();
    test_read_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
